// File: rtl/stack_return_unit_if.sv
// stack_return_unit_if: pipeline/memory-side bundle for the stack return unit.
//   master: memory stage / fetch / data-memory side (drives requests and read data)
//   slave : stack_return_unit (drives SP, memory read strobe and restored context)
interface stack_return_unit_if #(
    parameter int ADDR_W = 11
);
    logic              push_req;
    logic [ADDR_W-1:0] push_addr;
    logic              ret_start;
    logic              rti_start;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              busy;
    logic [31:0]       pc_out;
    logic              pc_valid;
    logic [2:0]        flags_out;
    logic              flags_load;
    logic [ADDR_W-1:0] sp_out;
    logic              stack_empty;

    modport master (
        output push_req, ret_start, rti_start, mem_rdata,
        input  push_addr, mem_rd_en, mem_addr, busy, pc_out, pc_valid,
               flags_out, flags_load, sp_out, stack_empty
    );

    modport slave (
        input  push_req, ret_start, rti_start, mem_rdata,
        output push_addr, mem_rd_en, mem_addr, busy, pc_out, pc_valid,
               flags_out, flags_load, sp_out, stack_empty
    );
endinterface

// File: rtl/stack_return_unit.sv
// stack_return_unit: owns SP and pops the RET/RTI return context from data memory.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of stack_return_unit_if (push, start pulses, memory read
//           port, stall, restored PC/flags, SP status)
module stack_return_unit #(
    parameter int                ADDR_W  = 11,
    parameter logic [ADDR_W-1:0] SP_INIT = 11'h7FF
) (
    input  logic                   clk,
    input  logic                   reset,
    stack_return_unit_if.slave     bus
);
    typedef enum logic [2:0] {IDLE, POP_F, POP_LO, POP_HI, FINISH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] sp_inc;
    logic              is_rti;
    logic [2:0]        flags_q;
    logic [15:0]       pc_lo;
    logic [31:0]       pc_q;
    logic [2:0]        flags_out_q;
    logic              pc_valid_q;
    logic              flags_load_q;

    assign sp_inc          = sp + ADDR_W'(1);
    assign bus.push_addr   = sp;
    assign bus.sp_out      = sp;
    assign bus.stack_empty = (sp == SP_INIT);
    assign bus.busy        = (state != IDLE);
    assign bus.mem_rd_en   = (state == POP_F) || (state == POP_LO) || (state == POP_HI);
    assign bus.mem_addr    = sp_inc;
    assign bus.pc_out      = pc_q;
    assign bus.pc_valid    = pc_valid_q;
    assign bus.flags_out   = flags_out_q;
    assign bus.flags_load  = flags_load_q;

    // Each POP state issues mem[SP+1] and captures the word issued by the
    // previous state, since data memory returns read data one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            sp           <= SP_INIT;
            is_rti       <= 1'b0;
            flags_q      <= '0;
            pc_lo        <= '0;
            pc_q         <= '0;
            flags_out_q  <= '0;
            pc_valid_q   <= 1'b0;
            flags_load_q <= 1'b0;
        end else begin
            pc_valid_q   <= 1'b0;
            flags_load_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rti_start) begin
                        state  <= POP_F;
                        is_rti <= 1'b1;
                    end else if (bus.ret_start) begin
                        state  <= POP_LO;
                        is_rti <= 1'b0;
                    end else if (bus.push_req) begin
                        sp <= sp - ADDR_W'(1);
                    end
                end
                POP_F: begin
                    sp    <= sp_inc;
                    state <= POP_LO;
                end
                POP_LO: begin
                    sp    <= sp_inc;
                    state <= POP_HI;
                    if (is_rti) flags_q <= bus.mem_rdata[2:0];
                end
                POP_HI: begin
                    sp    <= sp_inc;
                    pc_lo <= bus.mem_rdata;
                    state <= FINISH;
                end
                FINISH: begin
                    pc_q       <= {bus.mem_rdata, pc_lo};
                    pc_valid_q <= 1'b1;
                    state      <= IDLE;
                    if (is_rti) begin
                        flags_out_q  <= flags_q;
                        flags_load_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_return_unit.sv
// tb_stack_return_unit: directed self-checking bench for stack_return_unit.
module tb_stack_return_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stack_return_unit_if #(.ADDR_W(11)) bus0 ();
    stack_return_unit_if #(.ADDR_W(11)) bus1 ();

    stack_return_unit #(.ADDR_W(11), .SP_INIT(11'h7FF)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    stack_return_unit #(.ADDR_W(11), .SP_INIT(11'h000)) u1 (.clk(clk), .reset(reset), .bus(bus1));

    logic [15:0] mem0 [2048];
    logic [15:0] mem1 [2048];

    always @(posedge clk) begin
        if (bus0.mem_rd_en) bus0.mem_rdata <= mem0[bus0.mem_addr];
        if (bus1.mem_rd_en) bus1.mem_rdata <= mem1[bus1.mem_addr];
    end

    int total = 0;
    int bad = 0;
    int busy_cnt, pv_cnt, fl_cnt, pv_busy, pv_idx, fl_idx;
    logic [10:0] addrs [$];

    task automatic push(input bit sel, input logic [15:0] d, output logic [10:0] a);
        a = sel ? bus1.push_addr : bus0.push_addr;
        if (sel) begin
            mem1[a] = d;
            bus1.push_req = 1'b1;
        end else begin
            mem0[a] = d;
            bus0.push_req = 1'b1;
        end
        @(negedge clk);
        bus0.push_req = 1'b0;
        bus1.push_req = 1'b0;
    endtask

    // Records n cycles of activity; the start pulses are cleared on the first
    // cycle and a ret_start can be injected on cycle `inject`.
    task automatic observe(input bit sel, input int n, input int inject);
        logic b, rd, pv, fl;
        logic [10:0] ad;
        busy_cnt = 0; pv_cnt = 0; fl_cnt = 0; pv_busy = 0; pv_idx = -1; fl_idx = -1;
        addrs.delete();
        for (int i = 0; i < n; i++) begin
            bus0.rti_start = 1'b0;
            bus1.rti_start = 1'b0;
            bus0.ret_start = (i == inject);
            bus1.ret_start = 1'b0;
            b  = sel ? bus1.busy       : bus0.busy;
            rd = sel ? bus1.mem_rd_en  : bus0.mem_rd_en;
            ad = sel ? bus1.mem_addr   : bus0.mem_addr;
            pv = sel ? bus1.pc_valid   : bus0.pc_valid;
            fl = sel ? bus1.flags_load : bus0.flags_load;
            if (b) busy_cnt++;
            if (rd) addrs.push_back(ad);
            if (pv) begin pv_cnt++; pv_idx = i; if (b) pv_busy++; end
            if (fl) begin fl_cnt++; fl_idx = i; end
            @(negedge clk);
        end
        bus0.ret_start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus0.sp_out !== 11'h7FF) begin bad++; $display("FAIL reset_sp got=%h exp=7ff", bus0.sp_out); end
        total++; if (bus0.stack_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus0.stack_empty); end
        total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
        total++; if (bus0.pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus0.pc_out); end
        total++; if (bus0.flags_out !== 3'h0) begin bad++; $display("FAIL reset_flags got=%h exp=0", bus0.flags_out); end
        total++; if ({bus0.pc_valid, bus0.flags_load, bus0.mem_rd_en} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {bus0.pc_valid, bus0.flags_load, bus0.mem_rd_en}); end
        total++; if (bus1.sp_out !== 11'h000) begin bad++; $display("FAIL reset_sp1 got=%h exp=000", bus1.sp_out); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rti;
        logic [10:0] a;
        logic [15:0] d [3] = '{16'h0001, 16'h2345, 16'h0005};
        logic [10:0] ea [3] = '{11'h7FF, 11'h7FE, 11'h7FD};
        for (int i = 0; i < 3; i++) begin
            push(1'b0, d[i], a);
            total++; if (a !== ea[i]) begin bad++; $display("FAIL rti_push_addr%0d got=%h exp=%h", i, a, ea[i]); end
        end
        total++; if (bus0.sp_out !== 11'h7FC) begin bad++; $display("FAIL rti_sp_after_push got=%h exp=7fc", bus0.sp_out); end
        bus0.rti_start = 1'b1;
        @(negedge clk);
        observe(1'b0, 10, -1);
        total++;
        if (addrs.size() !== 3) begin bad++; $display("FAIL rti_addr_count got=%0d exp=3", addrs.size()); end
        else if (addrs[0] !== 11'h7FD || addrs[1] !== 11'h7FE || addrs[2] !== 11'h7FF) begin
            bad++; $display("FAIL rti_addr_seq got=%h,%h,%h exp=7fd,7fe,7ff", addrs[0], addrs[1], addrs[2]);
        end
        total++; if (busy_cnt !== 4) begin bad++; $display("FAIL rti_busy got=%0d exp=4", busy_cnt); end
        total++; if (pv_cnt !== 1 || pv_idx !== 4) begin bad++; $display("FAIL rti_pc_valid got=cnt%0d@%0d exp=cnt1@4", pv_cnt, pv_idx); end
        total++; if (fl_cnt !== 1 || fl_idx !== 4) begin bad++; $display("FAIL rti_flags_load got=cnt%0d@%0d exp=cnt1@4", fl_cnt, fl_idx); end
        total++; if (pv_busy !== 0) begin bad++; $display("FAIL rti_pv_busy got=%0d exp=0", pv_busy); end
        total++; if (bus0.pc_out !== 32'h00012345) begin bad++; $display("FAIL rti_pc got=%h exp=00012345", bus0.pc_out); end
        total++; if (bus0.flags_out !== 3'b101) begin bad++; $display("FAIL rti_flags got=%b exp=101", bus0.flags_out); end
        total++; if (bus0.sp_out !== 11'h7FF) begin bad++; $display("FAIL rti_sp got=%h exp=7ff", bus0.sp_out); end
        total++; if (bus0.stack_empty !== 1'b1) begin bad++; $display("FAIL rti_empty got=%b exp=1", bus0.stack_empty); end
    endtask

    task automatic test_ret;
        logic [10:0] a0, a1;
        push(1'b0, 16'h0000, a0);
        push(1'b0, 16'h0040, a1);
        total++; if (a0 !== 11'h7FF || a1 !== 11'h7FE) begin bad++; $display("FAIL ret_push_addr got=%h,%h exp=7ff,7fe", a0, a1); end
        total++; if (bus0.stack_empty !== 1'b0) begin bad++; $display("FAIL ret_not_empty got=%b exp=0", bus0.stack_empty); end
        bus0.ret_start = 1'b1;
        @(negedge clk);
        observe(1'b0, 8, -1);
        total++;
        if (addrs.size() !== 2) begin bad++; $display("FAIL ret_addr_count got=%0d exp=2", addrs.size()); end
        else if (addrs[0] !== 11'h7FE || addrs[1] !== 11'h7FF) begin
            bad++; $display("FAIL ret_addr_seq got=%h,%h exp=7fe,7ff", addrs[0], addrs[1]);
        end
        total++; if (busy_cnt !== 3) begin bad++; $display("FAIL ret_busy got=%0d exp=3", busy_cnt); end
        total++; if (pv_cnt !== 1 || pv_idx !== 3) begin bad++; $display("FAIL ret_pc_valid got=cnt%0d@%0d exp=cnt1@3", pv_cnt, pv_idx); end
        total++; if (fl_cnt !== 0) begin bad++; $display("FAIL ret_flags_load got=%0d exp=0", fl_cnt); end
        total++; if (bus0.pc_out !== 32'h00000040) begin bad++; $display("FAIL ret_pc got=%h exp=00000040", bus0.pc_out); end
        total++; if (bus0.flags_out !== 3'b101) begin bad++; $display("FAIL ret_flags_kept got=%b exp=101", bus0.flags_out); end
        total++; if (bus0.sp_out !== 11'h7FF) begin bad++; $display("FAIL ret_sp got=%h exp=7ff", bus0.sp_out); end
    endtask

    task automatic test_simultaneous;
        logic [10:0] a;
        push(1'b0, 16'hBEEF, a);
        push(1'b0, 16'h1234, a);
        push(1'b0, 16'h0002, a);
        bus0.rti_start = 1'b1;
        bus0.ret_start = 1'b1;
        @(negedge clk);
        observe(1'b0, 10, 2);
        total++; if (busy_cnt !== 4) begin bad++; $display("FAIL both_busy got=%0d exp=4", busy_cnt); end
        total++; if (pv_cnt !== 1 || pv_idx !== 4) begin bad++; $display("FAIL both_pc_valid got=cnt%0d@%0d exp=cnt1@4", pv_cnt, pv_idx); end
        total++; if (fl_cnt !== 1) begin bad++; $display("FAIL both_flags_load got=%0d exp=1", fl_cnt); end
        total++; if (bus0.pc_out !== 32'hBEEF1234) begin bad++; $display("FAIL both_pc got=%h exp=beef1234", bus0.pc_out); end
        total++; if (bus0.flags_out !== 3'b010) begin bad++; $display("FAIL both_flags got=%b exp=010", bus0.flags_out); end
        total++; if (bus0.sp_out !== 11'h7FF) begin bad++; $display("FAIL both_sp got=%h exp=7ff", bus0.sp_out); end
    endtask

    task automatic test_wrap;
        logic [10:0] a;
        mem1[1] = 16'h00AB;
        push(1'b1, 16'h0077, a);
        total++; if (a !== 11'h000) begin bad++; $display("FAIL wrap_push_addr got=%h exp=000", a); end
        total++; if (bus1.sp_out !== 11'h7FF) begin bad++; $display("FAIL wrap_sp_dec got=%h exp=7ff", bus1.sp_out); end
        bus1.ret_start = 1'b1;
        @(negedge clk);
        observe(1'b1, 8, -1);
        total++;
        if (addrs.size() !== 2) begin bad++; $display("FAIL wrap_addr_count got=%0d exp=2", addrs.size()); end
        else if (addrs[0] !== 11'h000 || addrs[1] !== 11'h001) begin
            bad++; $display("FAIL wrap_addr_seq got=%h,%h exp=000,001", addrs[0], addrs[1]);
        end
        total++; if (bus1.pc_out !== 32'h00AB0077) begin bad++; $display("FAIL wrap_pc got=%h exp=00ab0077", bus1.pc_out); end
        total++; if (bus1.sp_out !== 11'h001) begin bad++; $display("FAIL wrap_sp got=%h exp=001", bus1.sp_out); end
        total++; if (busy_cnt !== 3 || fl_cnt !== 0) begin bad++; $display("FAIL wrap_busy_fl got=%0d,%0d exp=3,0", busy_cnt, fl_cnt); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] a;
        push(1'b0, 16'h1111, a);
        push(1'b0, 16'h2222, a);
        push(1'b0, 16'h0003, a);
        bus0.rti_start = 1'b1;
        @(negedge clk);
        bus0.rti_start = 1'b0;
        @(negedge clk);
        total++; if (bus0.busy !== 1'b1 || bus0.mem_addr !== 11'h7FE) begin bad++; $display("FAIL mid_in_pop_lo got=busy%b addr%h exp=busy1 addr7fe", bus0.busy, bus0.mem_addr); end
        reset = 1'b0;
        #1;
        total++; if (bus0.busy !== 1'b0 || bus0.mem_rd_en !== 1'b0) begin bad++; $display("FAIL mid_async_drop got=busy%b rd%b exp=00", bus0.busy, bus0.mem_rd_en); end
        total++; if (bus0.sp_out !== 11'h7FF) begin bad++; $display("FAIL mid_sp_reset got=%h exp=7ff", bus0.sp_out); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        observe(1'b0, 8, -1);
        total++; if (pv_cnt !== 0 || fl_cnt !== 0 || busy_cnt !== 0) begin bad++; $display("FAIL mid_no_pulses got=pv%0d fl%0d busy%0d exp=0,0,0", pv_cnt, fl_cnt, busy_cnt); end
        total++; if (bus0.sp_out !== 11'h7FF) begin bad++; $display("FAIL mid_sp_after got=%h exp=7ff", bus0.sp_out); end
        total++; if (bus0.pc_out !== 32'h0 || bus0.flags_out !== 3'h0) begin bad++; $display("FAIL mid_outputs got=%h,%h exp=0,0", bus0.pc_out, bus0.flags_out); end
    endtask

    initial begin
        bus0.push_req = 1'b0; bus0.ret_start = 1'b0; bus0.rti_start = 1'b0; bus0.mem_rdata = 16'h0;
        bus1.push_req = 1'b0; bus1.ret_start = 1'b0; bus1.rti_start = 1'b0; bus1.mem_rdata = 16'h0;
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = 16'h0;
            mem1[i] = 16'h0;
        end
        test_reset;
        test_rti;
        test_ret;
        test_simultaneous;
        test_wrap;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
